// File: rtl/sdram_ar_ctrl.sv
// SDRAM auto-refresh controller: interval timer with refresh debt, bus request,
// and a granted PRECHARGE-all followed by a burst of AUTO REFRESH commands.
module sdram_ar_ctrl #(
  parameter int REF_INTERVAL = 750,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int REF_BURST    = 1,
  parameter int MAX_DEBT     = 8,
  parameter int URGENT_THR   = 4,
  parameter int ADDR_W       = 12,
  parameter int BA_W         = 2
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              init_done,
  input  logic                              ar_en,
  output logic                              ar_req,
  output logic                              ar_urgent,
  output logic                              ar_end,
  output logic                              ar_busy,
  output logic [3:0]                        ar_cmdo,
  output logic [BA_W-1:0]                   ar_bao,
  output logic [ADDR_W-1:0]                 ar_addro,
  output logic [$clog2(MAX_DEBT+1)-1:0]     ref_debt,
  output logic                              ref_overrun,
  output logic [2:0]                        ar_state
);

  localparam int DEBT_W   = $clog2(MAX_DEBT + 1);
  localparam int CNT_W    = $clog2(REF_INTERVAL);
  localparam int WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int BURST_W  = $clog2(REF_BURST + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(REF_INTERVAL - 1);
  localparam logic [DEBT_W-1:0]  DEBT_MAX  = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0]  DEBT_URG  = DEBT_W'(URGENT_THR);
  localparam logic [WAIT_W-1:0]  RP_LOAD   = WAIT_W'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [WAIT_W-1:0]  RFC_LOAD  = WAIT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(REF_BURST);
  localparam logic [ADDR_W-1:0]  ADDR_A10  = ADDR_W'(1) << 10;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_TRP  = 3'd2,
    S_AREF = 3'd3,
    S_TRFC = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DEBT_W-1:0]    debt_q, debt_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 end_q, end_d;
  logic                 ovr_q, ovr_d;
  logic                 req_q, urg_q, busy_q;
  logic                 tick, aref;

  always_comb begin
    tick    = init_done && (cnt_q == CNT_LAST);
    aref    = (state_q == S_AREF);
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    debt_d  = debt_q;
    ovr_d   = ovr_q | (tick && (debt_q == DEBT_MAX));
    // A tick and an AUTO REFRESH in the same cycle cancel out.
    if (tick && !aref && (debt_q != DEBT_MAX)) begin
      debt_d = debt_q + DEBT_W'(1);
    end else if (aref && !tick && (debt_q != '0)) begin
      debt_d = debt_q - DEBT_W'(1);
    end

    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    cmd_d   = CMD_NOP;
    addr_d  = '0;
    end_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ar_en && (debt_q != '0)) begin
          state_d = S_PRE;
          cmd_d   = CMD_PRE;
          addr_d  = ADDR_A10;
        end
      end
      S_PRE: begin
        burst_d = '0;
        if (T_RP == 1) begin
          state_d = S_AREF;
          cmd_d   = CMD_AREF;
        end else begin
          state_d = S_TRP;
          wait_d  = RP_LOAD;
        end
      end
      S_TRP: begin
        if (wait_q == '0) begin
          state_d = S_AREF;
          cmd_d   = CMD_AREF;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_AREF: begin
        burst_d = burst_q + BURST_W'(1);
        if (T_RFC > 1) begin
          state_d = S_TRFC;
          wait_d  = RFC_LOAD;
        end else if ((burst_d < BURST_MAX) && (debt_d != '0)) begin
          state_d = S_AREF;
          cmd_d   = CMD_AREF;
        end else begin
          state_d = S_DONE;
          end_d   = 1'b1;
        end
      end
      S_TRFC: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if ((burst_q < BURST_MAX) && (debt_q != '0)) begin
          state_d = S_AREF;
          cmd_d   = CMD_AREF;
        end else begin
          state_d = S_DONE;
          end_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Losing initialisation abandons any refresh work and the accrued debt.
    if (!init_done) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      debt_d  = '0;
      wait_d  = '0;
      burst_d = '0;
      cmd_d   = CMD_NOP;
      addr_d  = '0;
      end_d   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      debt_q  <= '0;
      wait_q  <= '0;
      burst_q <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      end_q   <= 1'b0;
      ovr_q   <= 1'b0;
      req_q   <= 1'b0;
      urg_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      debt_q  <= debt_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      ovr_q   <= ovr_d;
      req_q   <= (state_d == S_IDLE) && (debt_d != '0);
      urg_q   <= (debt_d >= DEBT_URG);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign ar_req      = req_q;
  assign ar_urgent   = urg_q;
  assign ar_end      = end_q;
  assign ar_busy     = busy_q;
  assign ar_cmdo     = cmd_q;
  assign ar_bao      = '0;
  assign ar_addro    = addr_q;
  assign ref_debt    = debt_q;
  assign ref_overrun = ovr_q;
  assign ar_state    = state_q;

endmodule

// File: tb/tb_sdram_ar_ctrl.sv
// Bench for sdram_ar_ctrl: a schedule-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sdram_ar_ctrl;

  localparam int RI    = 16;
  localparam int TRP   = 2;
  localparam int TRFC  = 7;
  localparam int BURST = 2;
  localparam int MAXD  = 8;
  localparam int UTHR  = 4;

  localparam int NOP  = 7;
  localparam int PRE  = 2;
  localparam int AREF = 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_done = 1'b0;
  logic        ar_en = 1'b0;
  logic        ar_req, ar_urgent, ar_end, ar_busy, ref_overrun;
  logic [3:0]  ar_cmdo;
  logic [1:0]  ar_bao;
  logic [11:0] ar_addro;
  logic [3:0]  ref_debt;
  logic [2:0]  ar_state;

  always #5 sys_clk = ~sys_clk;

  sdram_ar_ctrl #(
    .REF_INTERVAL(RI), .T_RP(TRP), .T_RFC(TRFC), .REF_BURST(BURST),
    .MAX_DEBT(MAXD), .URGENT_THR(UTHR), .ADDR_W(12), .BA_W(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done), .ar_en(ar_en),
    .ar_req(ar_req), .ar_urgent(ar_urgent), .ar_end(ar_end), .ar_busy(ar_busy),
    .ar_cmdo(ar_cmdo), .ar_bao(ar_bao), .ar_addro(ar_addro),
    .ref_debt(ref_debt), .ref_overrun(ref_overrun), .ar_state(ar_state)
  );

  int n_assert = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: debt/interval as plain arithmetic, commands from offset since PRECHARGE.
  int m_cnt = 0, m_debt = 0, m_off = -1;
  bit m_ovr = 0;
  int exp_cmd = NOP, exp_addr = 0;
  bit exp_end = 0, exp_req = 0, exp_urg = 0, exp_busy = 0;

  always @(posedge sys_clk) begin : model
    int n_cnt, n_debt, n_off, rel, k, n_cmd, n_addr;
    bit tick, issued, n_end;
    if (sys_rst) begin
      m_cnt = 0; m_debt = 0; m_off = -1; m_ovr = 0;
      exp_cmd = NOP; exp_addr = 0; exp_end = 0; exp_req = 0; exp_urg = 0; exp_busy = 0;
    end else if (!init_done) begin
      m_cnt = 0; m_debt = 0; m_off = -1;
      exp_cmd = NOP; exp_addr = 0; exp_end = 0; exp_req = 0; exp_urg = 0; exp_busy = 0;
    end else begin
      tick   = (m_cnt == RI - 1);
      issued = (exp_cmd == AREF);
      n_cnt  = tick ? 0 : m_cnt + 1;
      n_debt = m_debt;
      if (tick && m_debt == MAXD) m_ovr = 1;
      if (tick && !issued) n_debt = (m_debt < MAXD) ? m_debt + 1 : MAXD;
      else if (issued && !tick) n_debt = m_debt - 1;
      if (m_off < 0) n_off = (ar_en && m_debt != 0) ? 0 : -1;
      else if (exp_end) n_off = -1;
      else n_off = m_off + 1;
      n_cmd = NOP; n_addr = 0; n_end = 0;
      if (n_off == 0) begin
        n_cmd = PRE; n_addr = 'h400;
      end else if (n_off > 0) begin
        rel = n_off - TRP;
        if (rel >= 0 && rel % TRFC == 0) begin
          k = rel / TRFC;
          if (k == 0 || (k < BURST && m_debt != 0)) n_cmd = AREF;
          else n_end = 1;
        end
      end
      m_cnt = n_cnt; m_debt = n_debt; m_off = n_off;
      exp_cmd = n_cmd; exp_addr = n_addr; exp_end = n_end;
      exp_busy = (n_off >= 0);
      exp_req = (n_off < 0) && (n_debt != 0);
      exp_urg = (n_debt >= UTHR);
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("cmd", ar_cmdo, exp_cmd);
      chk("addr", ar_addro, exp_addr);
      chk("bank", ar_bao, 0);
      chk("req", ar_req, exp_req);
      chk("urgent", ar_urgent, exp_urg);
      chk("end", ar_end, exp_end);
      chk("busy", ar_busy, exp_busy);
      chk("debt", ref_debt, m_debt);
      chk("overrun", ref_overrun, m_ovr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_model(input int debt, input int cnt, input string name);
    int b = 0;
    while (!(m_debt == debt && m_cnt == cnt) && b < 400) begin
      cyc(1);
      b++;
    end
    if (b >= 400) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: timeout waiting for debt %0d cnt %0d", name, debt, cnt);
    end
  endtask

  initial begin
    // Reset and held-off timer
    cyc(2);
    chk_en = 1'b1;
    chk("rst_cmd", ar_cmdo, 4'b0111);
    chk("rst_addr", ar_addro, 0);
    chk("rst_debt", ref_debt, 0);
    chk("rst_req", ar_req, 0);
    chk("rst_busy", ar_busy, 0);
    chk("rst_ovr", ref_overrun, 0);
    sys_rst = 1'b0;
    cyc(3);
    chk("hold_debt", ref_debt, 0);

    // First tick 16 cycles after init_done
    init_done = 1'b1;
    cyc(15);
    chk("t1_debt_pre", ref_debt, 0);
    chk("t1_req_pre", ar_req, 0);
    cyc(1);
    chk("t1_debt", ref_debt, 1);
    chk("t1_req", ar_req, 1);
    chk("t1_cmd", ar_cmdo, 4'b0111);

    // Single refresh from debt 1
    ar_en = 1'b1; cyc(1); ar_en = 1'b0;
    chk("s2_pre_cmd", ar_cmdo, 4'b0010);
    chk("s2_pre_addr", ar_addro, 12'h400);
    chk("s2_pre_busy", ar_busy, 1);
    cyc(2);
    chk("s2_aref", ar_cmdo, 4'b0001);
    cyc(7);
    chk("s2_end", ar_end, 1);
    chk("s2_debt", ref_debt, 0);
    chk("s2_req", ar_req, 0);
    cyc(1);
    chk("s2_idle", ar_busy, 0);

    // Burst of two from debt 3; a tick lands at c+15
    wait_model(3, 0, "s3_wait");
    ar_en = 1'b1; cyc(1); ar_en = 1'b0;
    cyc(2);
    chk("s3_aref0", ar_cmdo, 4'b0001);
    cyc(1);
    chk("s3_debt_a", ref_debt, 2);
    cyc(6);
    chk("s3_aref1", ar_cmdo, 4'b0001);
    cyc(1);
    chk("s3_debt_b", ref_debt, 1);
    cyc(5);
    chk("s3_debt_tick", ref_debt, 2);
    cyc(1);
    chk("s3_end", ar_end, 1);
    chk("s3_end_cmd", ar_cmdo, 4'b0111);
    chk("s3_end_req", ar_req, 0);
    cyc(1);
    chk("s3_req_again", ar_req, 1);

    // Starvation: urgent, saturation, overrun
    wait_model(3, 0, "s4_w3");
    chk("s4_urg3", ar_urgent, 0);
    wait_model(4, 0, "s4_w4");
    chk("s4_urg4", ar_urgent, 1);
    wait_model(8, 0, "s4_w8");
    chk("s4_debt8", ref_debt, 8);
    chk("s4_ovr_pre", ref_overrun, 0);
    cyc(16);
    chk("s4_sat", ref_debt, 8);
    chk("s4_ovr", ref_overrun, 1);
    cyc(20);
    chk("s4_ovr_sticky", ref_overrun, 1);

    // Tick coinciding with AREF at debt 2
    sys_rst = 1'b1; cyc(1); sys_rst = 1'b0;
    chk("s5_ovr_clr", ref_overrun, 0);
    wait_model(2, 12, "s5_wait");
    ar_en = 1'b1; cyc(1); ar_en = 1'b0;
    cyc(2);
    chk("s5_aref", ar_cmdo, 4'b0001);
    chk("s5_debt_at", ref_debt, 2);
    cyc(1);
    chk("s5_debt_hold", ref_debt, 2);

    // Reset during TRFC
    cyc(1);
    sys_rst = 1'b1; cyc(1);
    chk("s6_state", ar_state, 0);
    chk("s6_cmd", ar_cmdo, 4'b0111);
    chk("s6_debt", ref_debt, 0);
    chk("s6_busy", ar_busy, 0);
    chk("s6_end", ar_end, 0);
    sys_rst = 1'b0;
    cyc(12);
    chk("s6_no_end", ar_end, 0);

    // init_done dropped mid-sequence
    wait_model(1, 0, "s7_wait");
    ar_en = 1'b1; cyc(1); ar_en = 1'b0;
    cyc(1);
    init_done = 1'b0; cyc(1);
    chk("s7_busy", ar_busy, 0);
    chk("s7_debt", ref_debt, 0);
    chk("s7_cmd", ar_cmdo, 4'b0111);
    init_done = 1'b1;
    cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
